matrix_win_ctrl: RTL and testbench



---
 rtl/matrix_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/matrix_win_ctrl.sv | 163 ++++++++++++++++
 tb/tb_matrix_win_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 window sequencing controller.
// Counter width and window pipeline depth are fixed here for all users.
package matrix_pkg;

  localparam int CNT_W   = 12;
  localparam int WIN_LAT = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    PRIME      = 2'd1,
    RUN        = 2'd2,
    RESYNC     = 2'd3
  } state_t;

  typedef struct packed {
    logic vld;
    cnt_t x;
    cnt_t y;
  } win_stage_t;

endpackage

// File: rtl/sync_edge_det.sv
// Sync start detector: pulses on the cycle a sync input enters its
// active level, using one registered copy of the previous level.
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic start
);

  logic act;
  logic act_q;

  assign act = (sig == POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
    end else begin
      act_q <= act;
    end
  end

  assign start = act & ~act_q;

endmodule

// File: rtl/matrix_win_ctrl.sv
// Line-buffer sequencing for a 3x3 window: tracks pixel position,
// drives FIFO/shift enables, flags valid windows, recovers from bad sync.
module matrix_win_ctrl
  import matrix_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int VS_POL     = 1,
  parameter int HS_POL     = 1
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic        video_vs,
  input  logic        video_hs,
  input  logic        video_de,
  output logic        fifo_wr_en,
  output logic        fifo_rd_en,
  output logic        fifo_flush,
  output logic        shift_en,
  output logic        win_valid,
  output logic [11:0] win_x,
  output logic [11:0] win_y,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err
);

  localparam cnt_t X_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam cnt_t Y_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam cnt_t ONE    = CNT_W'(1);
  localparam cnt_t TWO    = CNT_W'(2);

  state_t     state;
  state_t     state_nxt;
  cnt_t       x_cnt;
  cnt_t       y_cnt;
  cnt_t       x_nxt;
  cnt_t       y_nxt;
  win_stage_t s1;

  logic vs_start;
  logic hs_start;
  logic active;
  logic accept;
  logic x_wrap;
  logic last_px;
  logic l_err;
  logic f_err;
  logic done_nxt;

  sync_edge_det #(
    .POL (VS_POL != 0)
  ) u_vs_det (
    .clk   (video_clk),
    .rst   (rst),
    .sig   (video_vs),
    .start (vs_start)
  );

  sync_edge_det #(
    .POL (HS_POL != 0)
  ) u_hs_det (
    .clk   (video_clk),
    .rst   (rst),
    .sig   (video_hs),
    .start (hs_start)
  );

  assign active  = (state == PRIME) || (state == RUN);
  assign accept  = active && video_de;
  assign x_wrap  = (x_cnt == X_LAST);
  assign last_px = accept && x_wrap && (y_cnt == Y_LAST);

  assign l_err = active && hs_start && (x_cnt != '0);

  // A vs_start landing on the last pixel is the next frame, not an error
  assign f_err = active && vs_start && !last_px
              && ((x_cnt != '0) || (y_cnt != '0));

  assign done_nxt = last_px && !l_err;

  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    unique case (state)
      WAIT_FRAME: begin
        if (vs_start) begin
          state_nxt = PRIME;
        end
      end
      PRIME, RUN: begin
        if (l_err || f_err) begin
          state_nxt = RESYNC;
          x_nxt     = '0;
          y_nxt     = '0;
        end else if (last_px) begin
          state_nxt = vs_start ? PRIME : WAIT_FRAME;
          x_nxt     = '0;
          y_nxt     = '0;
        end else if (accept) begin
          if (x_wrap) begin
            x_nxt = '0;
            y_nxt = y_cnt + ONE;
            if ((state == PRIME) && (y_cnt == ONE)) begin
              state_nxt = RUN;
            end
          end else begin
            x_nxt = x_cnt + ONE;
          end
        end
      end
      RESYNC: begin
        state_nxt = WAIT_FRAME;
      end
    endcase
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_FRAME;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_cnt      <= x_nxt;
      y_cnt      <= y_nxt;
      frame_done <= done_nxt;
      line_err   <= l_err;
      frame_err  <= f_err;
    end
  end

  assign fifo_wr_en = accept && (y_cnt < Y_LAST);
  assign fifo_rd_en = accept && (y_cnt != '0);
  assign shift_en   = accept;
  assign fifo_flush = (state == RESYNC);

  // Two-stage window tag pipeline, matching the line-buffer datapath delay
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else begin
      s1.vld <= accept;
      if (accept) begin
        s1.x <= x_cnt;
        s1.y <= y_cnt;
      end
      win_valid <= s1.vld && (s1.x >= TWO) && (s1.y >= TWO);
      if (s1.vld) begin
        win_x <= s1.x - ONE;
        win_y <= s1.y - ONE;
      end
    end
  end

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// Directed bench for matrix_win_ctrl on a 5x4 image.
// Vector table for the line-error sequence, hand sequences elsewhere.
module tb_matrix_win_ctrl;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int c;
    int x;
    int y;
  } win_t;

  logic        video_clk = 1'b0;
  logic        rst = 1'b1;
  logic        video_vs = 1'b0;
  logic        video_hs = 1'b0;
  logic        video_de = 1'b0;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic        fifo_flush;
  logic        shift_en;
  logic        win_valid;
  logic [11:0] win_x;
  logic [11:0] win_y;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int n_wr, n_rd, n_flush, n_lerr, n_ferr;
  int p0, p1;
  logic [7:0] last;
  win_t wq[$];
  int   dq[$];
  vec_t vt[$];

  int exp_wx[6] = '{1, 2, 3, 1, 2, 3};
  int exp_wy[6] = '{1, 1, 1, 2, 2, 2};
  int exp_wc[6] = '{14, 15, 16, 19, 20, 21};

  matrix_win_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .VS_POL     (1),
    .HS_POL     (1)
  ) dut (
    .video_clk  (video_clk),
    .rst        (rst),
    .video_vs   (video_vs),
    .video_hs   (video_hs),
    .video_de   (video_de),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_flush (fifo_flush),
    .shift_en   (shift_en),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  always #5 video_clk = ~video_clk;

  function automatic logic [7:0] outs();
    return {fifo_wr_en, fifo_rd_en, shift_en, fifo_flush,
            line_err, frame_err, frame_done, win_valid};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    cyc = 0;
    n_wr = 0;
    n_rd = 0;
    n_flush = 0;
    n_lerr = 0;
    n_ferr = 0;
    wq.delete();
    dq.delete();
  endtask

  task automatic tick(input logic v, input logic h, input logic d);
    @(negedge video_clk);
    video_vs = v;
    video_hs = h;
    video_de = d;
    #1;
    last = outs();
    if (win_valid) wq.push_back('{cyc, int'(win_x), int'(win_y)});
    if (frame_done) dq.push_back(cyc);
    n_wr    += int'(fifo_wr_en);
    n_rd    += int'(fifo_rd_en);
    n_flush += int'(fifo_flush);
    n_lerr  += int'(line_err);
    n_ferr  += int'(frame_err);
    cyc++;
  endtask

  task automatic do_reset();
    video_vs = 1'b0;
    video_hs = 1'b0;
    video_de = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge video_clk);
    rst = 1'b0;
    clr();
  endtask

  task automatic feed(input int gap, input bit hs_ln,
                      input bit vs_last);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        tick(vs_last && (x == W-1) && (y == H-1),
             hs_ln && (x == 0), 1'b1);
        if (x == 2) repeat (gap) tick(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic chk_wins(input string nm, input int base,
                          input int p, input bit timed);
    for (int i = 0; i < 6; i++) begin
      if (base + i < wq.size()) begin
        chk({nm, "_x"}, wq[base+i].x, exp_wx[i]);
        chk({nm, "_y"}, wq[base+i].y, exp_wy[i]);
        if (timed) chk({nm, "_t"}, wq[base+i].c - p, exp_wc[i]);
      end else begin
        chk({nm, "_missing"}, wq.size(), base + 6);
      end
    end
  endtask

  initial begin
    // line-error vectors: {vs,hs,de} -> {wr,rd,sh,fl,le,fe,dn,wv}
    vt.push_back('{1'b1, 1'b0, 1'b0, 8'b0000_0000});
    repeat (5) vt.push_back('{1'b0, 1'b0, 1'b1, 8'b1010_0000});
    repeat (8) vt.push_back('{1'b0, 1'b0, 1'b1, 8'b1110_0000});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'b0000_0000});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'b0001_1001});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'b0000_0000});
    vt.push_back('{1'b0, 1'b1, 1'b1, 8'b0000_0000});
    vt.push_back('{1'b1, 1'b0, 1'b0, 8'b0000_0000});
    repeat (2) vt.push_back('{1'b0, 1'b0, 1'b1, 8'b1010_0000});

    // reset state and idle de before any vs
    do_reset();
    tick(1'b0, 1'b0, 1'b1);
    chk("reset_outs", int'(last), 0);
    chk("reset_wx", int'(win_x), 0);
    chk("reset_wy", int'(win_y), 0);

    // contiguous frame
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    p0 = cyc;
    feed(0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("c_nwin", wq.size(), 6);
    chk_wins("c_win", 0, p0, 1'b1);
    chk("c_wr", n_wr, 15);
    chk("c_rd", n_rd, 15);
    chk("c_ndone", dq.size(), 1);
    if (dq.size() > 0) chk("c_done_t", dq[0] - p0, 20);
    chk("c_errs", n_lerr + n_ferr + n_flush, 0);

    // gapped lines with hs at each line start
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    feed(2, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("g_nwin", wq.size(), 6);
    chk_wins("g_win", 0, 0, 1'b0);
    chk("g_lerr", n_lerr, 0);
    chk("g_ndone", dq.size(), 1);
    chk("g_wr", n_wr, 15);

    // short line: hs after 3 pixels of row 2
    do_reset();
    foreach (vt[i]) begin
      tick(vt[i].vs, vt[i].hs, vt[i].de);
      chk($sformatf("le_vec%0d", i), int'(last), int'(vt[i].exp));
    end
    chk("le_nflush", n_flush, 1);

    // vs_start at (2,1), then a clean frame
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    repeat (7) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("fe_pulse", int'(last), 8'b0001_0100);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    p0 = cyc;
    feed(0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("fe_nferr", n_ferr, 1);
    chk("fe_nlerr", n_lerr, 0);
    chk("fe_nflush", n_flush, 1);
    chk("fe_nwin", wq.size(), 6);
    chk_wins("fe_win", 0, p0, 1'b1);

    // async reset mid-RUN at (3,2)
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    repeat (13) tick(1'b0, 1'b0, 1'b1);
    @(negedge video_clk);
    video_de = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("ar_outs", int'(outs()), 0);
    chk("ar_wx", int'(win_x), 0);
    chk("ar_wy", int'(win_y), 0);
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    n_wr = 0;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    chk("ar_noen", n_wr + int'(last), 0);
    chk("ar_nflush", n_flush, 0);

    // last pixel coincident with next vs
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    p0 = cyc;
    feed(0, 1'b0, 1'b1);
    p1 = cyc;
    feed(0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("co_ndone", dq.size(), 2);
    if (dq.size() > 1) begin
      chk("co_done0_t", dq[0] - p0, 20);
      chk("co_done1_t", dq[1] - p1, 20);
    end
    chk("co_ferr", n_ferr + n_lerr + n_flush, 0);
    chk("co_nwin", wq.size(), 12);
    chk_wins("co_w0", 0, p0, 1'b1);
    chk_wins("co_w1", 6, p1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
